// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM encoding.
package uart_pkg;
    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic [AW:0]      cnt;
    logic             doPush, doPop;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign dout   = mem[rdPtr];
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a byte FIFO,
// STATUS reports busy/full/overflow; the serial line comes straight from a flop.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'd256,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DataAddr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        irq_empty
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    txState_t       state, stateN;
    logic [BW-1:0]  baudCnt, baudN;
    logic [2:0]     bitIdx, bitN;
    logic [7:0]     shift, shiftN;
    logic           txReg, txN;
    logic           overflow;

    logic           selTx, selStat, wrTx, wrStat, busy;
    logic           fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [7:0]     fifoDout;
    logic [CW-1:0]  fifoCount;
    logic           unusedBits;

    assign selTx      = (DataAddr == BASE_ADDR + TXDATA_OFS);
    assign selStat    = (DataAddr == BASE_ADDR + STATUS_OFS);
    assign wrTx       = MemWrite && selTx;
    assign wrStat     = MemWrite && selStat;
    assign fifoPush   = wrTx && (!fifoFull || fifoPop);
    assign unusedBits = ^WriteData[31:8];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) uFifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifoPush),
        .pop   (fifoPop),
        .din   (WriteData[7:0]),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    assign busy      = (state != IDLE) || (fifoCount != '0);
    assign irq_empty = (state == IDLE) && fifoEmpty;
    assign tx        = txReg;

    always_comb begin
        ReadData = 32'd0;
        if (selStat) begin
            ReadData[STAT_BUSY] = busy;
            ReadData[STAT_FULL] = fifoFull;
            ReadData[STAT_OVF]  = overflow;
        end
    end

    // A set from a dropped byte wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (wrTx && fifoFull && !fifoPop)
            overflow <= 1'b1;
        else if (wrStat && WriteData[STAT_OVF])
            overflow <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baudCnt <= '0;
            bitIdx  <= '0;
            shift   <= '0;
            txReg   <= 1'b1;
        end else begin
            state   <= stateN;
            baudCnt <= baudN;
            bitIdx  <= bitN;
            shift   <= shiftN;
            txReg   <= txN;
        end
    end

    // txN is the line level for the next cycle, so tx changes with the state.
    always_comb begin
        stateN  = state;
        baudN   = baudCnt;
        bitN    = bitIdx;
        shiftN  = shift;
        txN     = txReg;
        fifoPop = 1'b0;
        case (state)
            IDLE: begin
                txN = 1'b1;
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    shiftN  = fifoDout;
                    baudN   = '0;
                    stateN  = START;
                    txN     = 1'b0;
                end
            end
            START: begin
                if (baudCnt == BAUD_LAST) begin
                    baudN  = '0;
                    bitN   = '0;
                    stateN = DATA;
                    txN    = shift[0];
                end else begin
                    baudN = baudCnt + 1'b1;
                end
            end
            DATA: begin
                if (baudCnt == BAUD_LAST) begin
                    baudN = '0;
                    if (bitIdx == 3'd7) begin
                        stateN = STOP;
                        txN    = 1'b1;
                    end else begin
                        bitN   = bitIdx + 1'b1;
                        shiftN = {1'b0, shift[7:1]};
                        txN    = shift[1];
                    end
                end else begin
                    baudN = baudCnt + 1'b1;
                end
            end
            STOP: begin
                txN = 1'b1;
                if (baudCnt == BAUD_LAST) begin
                    baudN  = '0;
                    stateN = IDLE;
                end else begin
                    baudN = baudCnt + 1'b1;
                end
            end
            default: begin
                stateN = IDLE;
                txN    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at CLKS_PER_BIT=4: register vector table,
// exact frame timing, FIFO fill/overflow, same-cycle push+pop and mid-frame reset.
module tb_mmio_uart_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] DataAddr = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] ReadData;
    logic        tx;
    logic        irq_empty;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    mmio_uart_tx #(.BASE_ADDR(32'd256), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .DataAddr  (DataAddr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .tx        (tx),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        DataAddr  = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic waitIdle(input int bound, input string nm);
        int n = 0;
        while (!irq_empty && n < bound) begin
            tick();
            n++;
        end
        check(nm, {31'd0, irq_empty}, 32'd1);
    endtask

    // Exact frame shape: start, 8 data LSB-first, stop, each 4 cycles.
    task automatic checkFrame(input logic [7:0] b, input string nm);
        logic [9:0] f = {1'b1, b, 1'b0};
        int errs = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (tx !== f[k/4]) errs++;
        end
        check(nm, errs, 0);
    endtask

    // Line receiver: samples mid-bit, records byte and start cycle.
    logic [7:0] rxQ[$];
    int         startQ[$];
    int         frameErr = 0;
    initial begin
        int         t0;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset && tx === 1'b0) begin
                t0 = cyc;
                repeat (6) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = tx;
                    if (i < 7) repeat (4) @(negedge clk);
                end
                repeat (4) @(negedge clk);
                if (tx !== 1'b1) frameErr++;
                rxQ.push_back(b);
                startQ.push_back(t0);
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] expRd;
        logic        expTx;
        logic        expIrq;
    } vec_t;

    vec_t vt[11];

    initial begin
        int n0;
        int errs;
        logic [7:0] exp35 [6];

        vt[0]  = '{1'b0, 32'd260, 32'd0,    32'd0, 1'b1, 1'b1};
        vt[1]  = '{1'b0, 32'd256, 32'd0,    32'd0, 1'b1, 1'b1};
        vt[2]  = '{1'b0, 32'd264, 32'd0,    32'd0, 1'b1, 1'b1};
        vt[3]  = '{1'b1, 32'd264, 32'h55,   32'd0, 1'b1, 1'b1};
        vt[4]  = '{1'b0, 32'd260, 32'd0,    32'd0, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 32'd260, 32'h4,    32'd0, 1'b1, 1'b1};
        vt[6]  = '{1'b0, 32'd0,   32'd0,    32'd0, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 32'd256, 32'h100,  32'd0, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 32'd260, 32'd0,    32'd1, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 32'd260, 32'd0,    32'd1, 1'b0, 1'b0};
        vt[10] = '{1'b0, 32'd256, 32'd0,    32'd0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset irq", {31'd0, irq_empty}, 32'd1);
        reset = 1'b1;
        tick();

        // Register-level vectors; vt[7] stores 0x100 so only byte 0x00 is pushed.
        for (int i = 0; i < 11; i++) begin
            DataAddr  = vt[i].addr;
            WriteData = vt[i].wd;
            MemWrite  = vt[i].we;
            #1;
            check($sformatf("vec%0d rd", i),  ReadData, vt[i].expRd);
            check($sformatf("vec%0d tx", i),  {31'd0, tx}, {31'd0, vt[i].expTx});
            check($sformatf("vec%0d irq", i), {31'd0, irq_empty}, {31'd0, vt[i].expIrq});
            tick();
            MemWrite = 1'b0;
        end
        waitIdle(100, "vec frame drain");
        repeat (2) tick();
        check("vec rx count", rxQ.size(), 1);
        if (rxQ.size() == 1) check("vec rx byte", {24'd0, rxQ[0]}, 32'd0);
        rxQ.delete();
        startQ.delete();

        // Single frame, cycle-exact, with busy before/after stop.
        store(32'd256, 32'd25);
        DataAddr = 32'd260;
        checkFrame(8'd25, "frame 25 shape");
        check("busy in stop", ReadData, 32'd1);
        tick();
        check("busy after stop", ReadData, 32'd0);
        check("irq after frame", {31'd0, irq_empty}, 32'd1);
        check("rx 25", rxQ.size() == 1 ? {24'd0, rxQ[0]} : 32'hFFFF_FFFF, 32'd25);
        rxQ.delete();
        startQ.delete();

        // Five consecutive stores: first pop frees a slot, all five accepted.
        for (int i = 0; i < 5; i++) store(32'd256, 32'h41 + i);
        DataAddr = 32'd260;
        #1;
        check("five stores status", ReadData, 32'd3);
        waitIdle(400, "five stores drain");
        repeat (2) tick();
        check("five rx count", rxQ.size(), 5);
        errs = 0;
        for (int i = 0; i < rxQ.size() && i < 5; i++)
            if (rxQ[i] !== 8'(8'h41 + i)) errs++;
        check("five rx order", errs, 0);
        errs = 0;
        for (int i = 1; i < startQ.size(); i++)
            if (startQ[i] - startQ[i-1] != 41) errs++;
        check("back-to-back gap", errs, 0);
        check("five no overflow", ReadData, 32'd0);
        rxQ.delete();
        startQ.delete();

        // Six stores: sixth dropped, overflow set then cleared via STATUS.
        store(32'd256, 32'h01);
        n0 = cyc;
        for (int i = 2; i <= 6; i++) store(32'd256, i);
        DataAddr = 32'd260;
        #1;
        check("six stores status", ReadData, 32'd7);
        store(32'd260, 32'd4);
        check("overflow cleared", ReadData, 32'd3);
        // Store on the exact edge that pops 0x02 while full: both succeed.
        while (cyc < n0 + 41) tick();
        check("full before push+pop", ReadData, 32'd3);
        store(32'd256, 32'h07);
        DataAddr = 32'd260;
        #1;
        check("push+pop full status", ReadData, 32'd3);
        waitIdle(400, "six stores drain");
        repeat (2) tick();
        exp35 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07};
        check("six rx count", rxQ.size(), 6);
        errs = 0;
        for (int i = 0; i < rxQ.size() && i < 6; i++)
            if (rxQ[i] !== exp35[i]) errs++;
        check("six rx bytes", errs, 0);
        rxQ.delete();
        startQ.delete();

        // Reset 15 cycles into a frame with a second byte still queued.
        store(32'd256, 32'h00);
        store(32'd256, 32'h3C);
        repeat (14) tick();
        check("mid-frame tx low", {31'd0, tx}, 32'd0);
        reset = 1'b0;
        #1;
        check("async reset tx", {31'd0, tx}, 32'd1);
        check("async reset irq", {31'd0, irq_empty}, 32'd1);
        repeat (2) tick();
        reset = 1'b1;
        DataAddr = 32'd260;
        #1;
        check("status after reset", ReadData, 32'd0);
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1) errs++;
        end
        check("no residual frame", errs, 0);
        check("irq after reset idle", {31'd0, irq_empty}, 32'd1);
        rxQ.delete();
        startQ.delete();

        check("stop bits", frameErr, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
